// File: rtl/perip_uart_tx_if.sv
// Peripheral bus bundle between the core (master) and the UART transmitter (slave).
interface perip_uart_tx_if;
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;
    logic        hit;

    modport master (
        output perip_addr, perip_wen, perip_mask, perip_wdata,
        input  perip_rdata, hit
    );

    modport slave (
        input  perip_addr, perip_wen, perip_mask, perip_wdata,
        output perip_rdata, hit
    );
endinterface

// File: rtl/perip_uart_tx.sv
// Memory-mapped UART transmitter with TX FIFO; 8N1 by default, 8E1 when
// PERIP_UART_PARITY_EN is defined.
module perip_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h8020_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic              clk,
    input  logic              rst_n,
    perip_uart_tx_if.slave    bus,
    output logic              uart_tx,
    output logic              tx_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    state_e          state_q;
    logic [15:0]     baud_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            uart_tx_q;
`ifdef PERIP_UART_PARITY_EN
    logic            par_q;
`endif
    logic [15:0]     baud_q;
    logic            ovf_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic [1:0]      reg_sel;
    logic            wr_en, push_req, push, pop;
    logic            full, empty, busy, bit_end;
    logic [15:0]     div_eff, bit_load;
    logic [7:0]      fifo_head;
    logic            unused_bus;

    assign bus.hit    = (bus.perip_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = bus.perip_addr[3:2];
    assign wr_en      = bus.hit && bus.perip_wen;
    assign push_req   = wr_en && (reg_sel == 2'd0) && (bus.perip_addr[1:0] == 2'b00);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = push_req && !full;
    assign busy       = (state_q != S_IDLE);
    assign bit_end    = (baud_cnt_q == '0);
    // STOP pops directly into the next START so frames run back to back.
    assign pop        = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
    assign div_eff    = (baud_q == '0) ? 16'd1 : baud_q;
    assign bit_load   = div_eff - 16'd1;
    assign fifo_head  = mem_q[rd_ptr_q];
    assign unused_bus = ^{bus.perip_mask, bus.perip_wdata[31:16]};

    assign uart_tx = uart_tx_q;
    assign tx_irq  = empty && !busy;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        bus.perip_rdata = '0;
        if (bus.hit) begin
            case (reg_sel)
                2'd1:    bus.perip_rdata = {24'd0, 4'(count_q), ovf_q, empty, full, busy};
                2'd2:    bus.perip_rdata = {16'd0, baud_q};
                default: bus.perip_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.perip_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_req && full)
                ovf_q <= 1'b1;
            else if (wr_en && (reg_sel == 2'd1) && bus.perip_wdata[3])
                ovf_q <= 1'b0;
            if (wr_en && (reg_sel == 2'd2)) baud_q <= bus.perip_wdata[15:0];
        end
    end

    // uart_tx follows the state one clock later, giving pop at E+1 and start bit at E+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
`ifdef PERIP_UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    uart_tx_q <= 1'b1;
                    if (pop) begin
                        shift_q    <= fifo_head;
`ifdef PERIP_UART_PARITY_EN
                        par_q      <= ^fifo_head;
`endif
                        baud_cnt_q <= bit_load;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    uart_tx_q <= 1'b0;
                    if (bit_end) begin
                        baud_cnt_q <= bit_load;
                        bit_idx_q  <= '0;
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    uart_tx_q <= shift_q[0];
                    if (bit_end) begin
                        baud_cnt_q <= bit_load;
                        shift_q    <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
`ifdef PERIP_UART_PARITY_EN
                            state_q <= S_PAR;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
`ifdef PERIP_UART_PARITY_EN
                S_PAR: begin
                    uart_tx_q <= par_q;
                    if (bit_end) begin
                        baud_cnt_q <= bit_load;
                        state_q    <= S_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    uart_tx_q <= 1'b1;
                    if (bit_end) begin
                        baud_cnt_q <= bit_load;
                        if (pop) begin
                            shift_q <= fifo_head;
`ifdef PERIP_UART_PARITY_EN
                            par_q   <= ^fifo_head;
`endif
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: begin
                    uart_tx_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_perip_uart_tx.sv
// Bench for perip_uart_tx: queue/frame-level model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_perip_uart_tx;
    localparam logic [31:0] BASE  = 32'h8020_0000;
    localparam int          DEPTH = 8;
`ifdef PERIP_UART_PARITY_EN
    localparam int NB = 11;
    localparam int BD = 44;
`else
    localparam int NB = 10;
    localparam int BD = 40;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx, tx_irq;

    perip_uart_tx_if bus ();

    perip_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .uart_tx(uart_tx),
        .tx_irq (tx_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus the frame currently on the wire as a bit list.
    logic [7:0]  byte_q [$];
    logic        m_ovf;
    logic [15:0] m_div;
    logic        m_in_frame;
    logic [10:0] m_frame;
    int          m_nbits, m_bi, m_rem, m_pre_n;
    logic        m_tx, m_start;
    logic [15:0] m_eff;
    logic [7:0]  m_b;
    logic        m_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q.delete();
            m_ovf = 1'b0; m_div = 16'd868; m_in_frame = 1'b0;
            m_tx = 1'b1; m_bi = 0; m_rem = 0; m_nbits = NB; m_frame = '1;
        end else begin
            m_pre_n = byte_q.size();
            m_eff   = (m_div == 16'd0) ? 16'd1 : m_div;
            m_tx    = m_in_frame ? m_frame[m_bi] : 1'b1;
            m_start = 1'b0;
            if (!m_in_frame) begin
                m_start = (m_pre_n != 0);
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_bi++;
                    m_rem = int'(m_eff);
                    if (m_bi == m_nbits) begin
                        m_in_frame = 1'b0;
                        m_start = (m_pre_n != 0);
                    end
                end
            end
            if (m_start) begin
                m_b = byte_q.pop_front();
`ifdef PERIP_UART_PARITY_EN
                m_frame = {1'b1, ^m_b, m_b, 1'b0};
`else
                m_frame = {1'b1, 1'b1, m_b, 1'b0};
`endif
                m_nbits = NB; m_bi = 0; m_rem = int'(m_eff); m_in_frame = 1'b1;
            end
            m_hit = (bus.perip_addr[31:4] == BASE[31:4]);
            if (m_hit && bus.perip_wen) begin
                case (bus.perip_addr[3:2])
                    2'd0: if (bus.perip_addr[1:0] == 2'b00) begin
                        if (m_pre_n == DEPTH) m_ovf = 1'b1;
                        else byte_q.push_back(bus.perip_wdata[7:0]);
                    end
                    2'd1: if (bus.perip_wdata[3]) m_ovf = 1'b0;
                    2'd2: m_div = bus.perip_wdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int n;
        n = byte_q.size();
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd1:    return {24'd0, 4'(n), m_ovf, (n == 0), (n == DEPTH), m_in_frame};
            2'd2:    return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("uart_tx", uart_tx, m_tx);
            check("tx_irq", tx_irq, (byte_q.size() == 0) && !m_in_frame);
            check("hit", bus.hit, bus.perip_addr[31:4] == BASE[31:4]);
            check("rdata", bus.perip_rdata, exp_rd(bus.perip_addr));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.perip_addr = a; bus.perip_wdata = d; bus.perip_wen = 1'b1; bus.perip_mask = 2'b11;
        @(posedge clk); #1;
        bus.perip_wen = 1'b0; bus.perip_addr = BASE + 32'h4;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.perip_addr = a; #1;
        check(name, bus.perip_rdata, exp);
        bus.perip_addr = BASE + 32'h4;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (tx_irq !== 1'b1 && k < budget) begin
            @(posedge clk); #1; k++;
        end
        check("idle_timeout", tx_irq, 1'b1);
    endtask

    logic        trace [48];
    logic        busyt [48];
    logic [10:0] fexp;

    initial begin
        bus.perip_addr = BASE + 32'h4; bus.perip_wen = 1'b0;
        bus.perip_mask = 2'b00; bus.perip_wdata = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_tx_irq", tx_irq, 1'b1);
        rd_chk("rst_status", BASE + 32'h4, 32'h04);
        rd_chk("rst_bauddiv", BASE + 32'h8, 32'd868);
        rst_n = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;

        // Single 0xA5 frame at 4 clocks per bit.
        wr(BASE + 32'h8, 32'd4);
        wr(BASE, 32'hA5);
        for (int c = 0; c < 48; c++) begin
            @(posedge clk); #1;
            trace[c] = uart_tx;
            busyt[c] = bus.perip_rdata[0];
        end
`ifdef PERIP_UART_PARITY_EN
        fexp = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        fexp = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
        check("a5_e1_idle", trace[0], 1'b1);
        check("a5_e2_start", trace[1], 1'b0);
        check("a5_start_last", trace[4], 1'b0);
        check("a5_bit0_first", trace[5], 1'b1);
        for (int i = 0; i < NB; i++) check($sformatf("a5_bit%0d", i), trace[4*i+3], fexp[i]);
        check("a5_busy_last", busyt[BD-1], 1'b1);
        check("a5_busy_drop", busyt[BD], 1'b0);
        wait_idle(100);

        // Fill the FIFO at one clock per bit, then overflow and clear.
        wr(BASE + 32'h8, 32'd1);
        for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i);
        rd_chk("nine_full", BASE + 32'h4, 32'h83);
        wr(BASE, 32'hEE);
        rd_chk("ovf_set", BASE + 32'h4, 32'h8B);
        wr(BASE + 32'h4, 32'h8);
        rd_chk("ovf_clear", BASE + 32'h4, 32'h83);
        wait_idle(200);

        // Pushes coinciding with the IDLE pop and with the STOP-end pop.
        wr(BASE + 32'h8, 32'd2);
        wr(BASE, 32'h3C);
        wr(BASE, 32'hC3);
        rd_chk("pushpop_idle", BASE + 32'h4, 32'h11);
        repeat (19) begin @(posedge clk); #1; end
        wr(BASE, 32'h96);
        rd_chk("pushpop_stop", BASE + 32'h4, 32'h11);
        wait_idle(200);

        // Non-zero byte lane, reserved register, out-of-window address.
        wr(BASE + 32'h1, 32'h0000_5500);
        rd_chk("lane_status", BASE + 32'h4, 32'h04);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd_chk("reserved_rd", BASE + 32'hC, 32'h0);
        rd_chk("baud_keep", BASE + 32'h8, 32'd2);
        repeat (3) begin @(posedge clk); #1; end
        check("lane_no_tx", tx_irq, 1'b1);
        bus.perip_addr = BASE + 32'h10; #1;
        check("miss_hit", bus.hit, 1'b0);
        check("miss_rdata", bus.perip_rdata, 32'h0);
        bus.perip_addr = BASE + 32'h4;

        // BAUDDIV of zero behaves as one clock per bit.
        wr(BASE + 32'h8, 32'd0);
        wr(BASE, 32'h81);
        wait_idle(50);

        // Asynchronous reset in the middle of the data bits.
        wr(BASE + 32'h8, 32'd4);
        wr(BASE, 32'hA5);
        wr(BASE, 32'h5A);
        repeat (10) begin @(posedge clk); #1; end
        check("pre_rst_line", uart_tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_uart_tx", uart_tx, 1'b1);
        check("arst_tx_irq", tx_irq, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("post_rst_status", BASE + 32'h4, 32'h04);
        rd_chk("post_rst_baud", BASE + 32'h8, 32'd868);
        repeat (30) begin @(posedge clk); #1; end
        check("post_rst_idle", uart_tx, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
